mem_arbiter_responder: RTL and testbench

//  Responder end of the cache<->memory protocol. Accepts word requests from the

---
 rtl/mem_arbiter_responder.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_responder.sv
// mem_arbiter_responder
//   Responder end of the cache<->memory protocol. Takes word requests from the
//   icache and the dcache, picks one, and runs a single RAM transaction at a
//   time. The dcache normally wins. After STARVE_MAX consecutive dcache grants
//   taken while the icache was waiting, the icache is given the next grant.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   iREN, iaddr        icache read request and word address
//   iwait, iload       icache handshake: iwait low for the completing cycle only
//   dREN, dWEN         dcache read / write request (write wins)
//   daddr, dstore      dcache word address and write data
//   dwait, dload       dcache handshake: dwait low for the completing cycle only
//   ramREN, ramWEN     RAM strobes
//   ramaddr, ramstore  word-aligned RAM address and write data
//   ramload, ram_ready RAM read data and access-complete indication

module mem_arbiter_responder #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dwait,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ram_ready
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          d_req;
  logic          starved;

  // The low address bits are always forced to zero on the RAM side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  assign d_req   = dREN | dWEN;
  assign starved = iREN && (starve_cnt == CNT_MAX);

  // Arbitration and transaction sequencing. Every transaction returns to IDLE,
  // which gives the one-cycle strobe drop between back-to-back accesses. If the
  // served request disappears before ram_ready, the transaction is abandoned
  // and ram_ready in that cycle is ignored.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !starved) begin
            state <= DSERVE;
          end else if (iREN) begin
            state <= ISERVE;
          end
        end
        DSERVE: begin
          if (!d_req) begin
            state <= IDLE;
          end else if (ram_ready) begin
            state <= IDLE;
            if (!iREN) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ISERVE: begin
          if (!iREN) begin
            state <= IDLE;
          end else if (ram_ready) begin
            state      <= IDLE;
            starve_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cache and RAM side outputs follow the current state and ram_ready directly,
  // so an abort or a reset drops the strobes in the same cycle.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DSERVE: begin
        if (d_req) begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = {daddr[AW-1:2], 2'b00};
          ramstore = dstore;
          if (ram_ready) begin
            dwait = 1'b0;
            if (!dWEN) begin
              dload = ramload;
            end
          end
        end
      end
      ISERVE: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = {iaddr[AW-1:2], 2'b00};
          if (ram_ready) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_responder.sv
// tb_mem_arbiter_responder
//   Directed bench for mem_arbiter_responder. Inputs are applied on the falling
//   edge and outputs are compared 1 time unit later, well away from the rising
//   edge where the arbiter state moves. The DUT is built with STARVE_MAX=2.

module tb_mem_arbiter_responder;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  int checks;
  int errors;

  mem_arbiter_responder #(
    .STARVE_MAX(2),
    .AW(32),
    .DW(32)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload),
    .dREN(dREN),
    .dWEN(dWEN),
    .daddr(daddr),
    .dstore(dstore),
    .dwait(dwait),
    .dload(dload),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Waits for the falling edge, drives one cycle's inputs, then lets the
  // combinational outputs settle before any check.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds,
                               input logic [31:0] rl, input logic rr);
    @(negedge CLK);
    iREN      = ir;
    iaddr     = ia;
    dREN      = dr;
    dWEN      = dw;
    daddr     = da;
    dstore    = ds;
    ramload   = rl;
    ram_ready = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic exp_i [6];
    checks    = 0;
    errors    = 0;
    nRST      = 1'b0;
    iREN      = 1'b0;
    iaddr     = '0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    ramload   = '0;
    ram_ready = 1'b0;
    #2;
    $display("[TB] reset values");
    checkOutput("rst_iwait", iwait, 1);
    checkOutput("rst_dwait", dwait, 1);
    checkOutput("rst_iload", iload, 0);
    checkOutput("rst_dload", dload, 0);
    checkOutput("rst_ramREN", ramREN, 0);
    checkOutput("rst_ramWEN", ramWEN, 0);
    checkOutput("rst_ramaddr", ramaddr, 0);
    checkOutput("rst_ramstore", ramstore, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // icache read with two wait cycles before ram_ready
    $display("[TB] icache read");
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("t1_idle_ramREN", ramREN, 0);
    checkOutput("t1_idle_iwait", iwait, 1);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    checkOutput("t1_ramREN", ramREN, 1);
    checkOutput("t1_ramaddr", ramaddr, 32'h40);
    checkOutput("t1_wait_iwait", iwait, 1);
    checkOutput("t1_wait_iload", iload, 0);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    checkOutput("t1_wait2_iwait", iwait, 1);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 1);
    checkOutput("t1_done_iwait", iwait, 0);
    checkOutput("t1_done_iload", iload, 32'hDEADBEEF);
    checkOutput("t1_done_dwait", dwait, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    checkOutput("t1_after_iwait", iwait, 1);
    checkOutput("t1_after_iload", iload, 0);
    checkOutput("t1_after_ramREN", ramREN, 0);

    // simultaneous requests: dcache first, one IDLE cycle, then icache
    $display("[TB] simultaneous requests");
    applyStimulus(1, 32'h80, 1, 0, 32'h104, 0, 32'h11111111, 1);
    checkOutput("t2_idle_ramREN", ramREN, 0);
    checkOutput("t2_idle_dwait", dwait, 1);
    checkOutput("t2_idle_iwait", iwait, 1);
    applyStimulus(1, 32'h80, 1, 0, 32'h104, 0, 32'h11111111, 1);
    checkOutput("t2_d_ramaddr", ramaddr, 32'h104);
    checkOutput("t2_d_dwait", dwait, 0);
    checkOutput("t2_d_dload", dload, 32'h11111111);
    checkOutput("t2_d_iwait", iwait, 1);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 32'h22222222, 1);
    checkOutput("t2_gap_ramREN", ramREN, 0);
    checkOutput("t2_gap_iwait", iwait, 1);
    checkOutput("t2_gap_dwait", dwait, 1);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 32'h22222222, 1);
    checkOutput("t2_i_ramaddr", ramaddr, 32'h80);
    checkOutput("t2_i_iwait", iwait, 0);
    checkOutput("t2_i_iload", iload, 32'h22222222);
    checkOutput("t2_i_dwait", dwait, 1);

    // starvation limit 2 with both requests held: D,D,I,D,D,I
    $display("[TB] starvation");
    exp_i = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int g = 0; g < 6; g++) begin
      applyStimulus(1, 32'h300, 1, 0, 32'h200, 0, 32'h5A5A0000, 1);
      checkOutput($sformatf("t3_idle%0d_ramREN", g), ramREN, 0);
      applyStimulus(1, 32'h300, 1, 0, 32'h200, 0, 32'h5A5A0000, 1);
      checkOutput($sformatf("t3_grant%0d_ramaddr", g), ramaddr,
                  exp_i[g] ? 32'h300 : 32'h200);
      checkOutput($sformatf("t3_grant%0d_iwait", g), iwait, exp_i[g] ? 0 : 1);
      checkOutput($sformatf("t3_grant%0d_dwait", g), dwait, exp_i[g] ? 1 : 0);
    end

    // dcache write with dREN also high
    $display("[TB] dcache write");
    applyStimulus(0, 0, 1, 1, 32'h3103, 32'h5, 32'hAAAA5555, 0);
    checkOutput("t4_idle_ramWEN", ramWEN, 0);
    applyStimulus(0, 0, 1, 1, 32'h3103, 32'h5, 32'hAAAA5555, 0);
    checkOutput("t4_ramWEN", ramWEN, 1);
    checkOutput("t4_ramREN", ramREN, 0);
    checkOutput("t4_ramaddr", ramaddr, 32'h3100);
    checkOutput("t4_ramstore", ramstore, 32'h5);
    checkOutput("t4_wait_dwait", dwait, 1);
    applyStimulus(0, 0, 1, 1, 32'h3103, 32'h5, 32'hAAAA5555, 1);
    checkOutput("t4_done_dwait", dwait, 0);
    checkOutput("t4_done_dload", dload, 0);

    // dcache read abandoned before ram_ready
    $display("[TB] abort");
    applyStimulus(0, 0, 1, 0, 32'h500, 0, 32'h77777777, 0);
    checkOutput("t5_idle_ramREN", ramREN, 0);
    applyStimulus(0, 0, 1, 0, 32'h500, 0, 32'h77777777, 0);
    checkOutput("t5_serve_ramREN", ramREN, 1);
    applyStimulus(0, 0, 0, 0, 32'h500, 0, 32'h77777777, 1);
    checkOutput("t5_abort_ramREN", ramREN, 0);
    checkOutput("t5_abort_ramWEN", ramWEN, 0);
    checkOutput("t5_abort_dwait", dwait, 1);
    checkOutput("t5_abort_dload", dload, 0);
    applyStimulus(0, 0, 1, 0, 32'h500, 0, 32'h77777777, 0);
    checkOutput("t5_back_idle_ramREN", ramREN, 0);
    applyStimulus(0, 0, 1, 0, 32'h500, 0, 32'h77777777, 0);
    checkOutput("t5_reserve_ramREN", ramREN, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_drop_ramREN", ramREN, 0);

    // reset in the middle of an icache read
    $display("[TB] reset during ISERVE");
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 32'h12345678, 0);
    checkOutput("t6_idle_ramREN", ramREN, 0);
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 32'h12345678, 0);
    checkOutput("t6_serve_ramREN", ramREN, 1);
    checkOutput("t6_serve_ramaddr", ramaddr, 32'h600);
    #1;
    nRST = 1'b0;
    #1;
    checkOutput("t6_rst_ramREN", ramREN, 0);
    checkOutput("t6_rst_ramaddr", ramaddr, 0);
    checkOutput("t6_rst_iwait", iwait, 1);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkOutput("t6_rel_ramREN", ramREN, 0);
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 32'h12345678, 1);
    checkOutput("t6_reserve_ramaddr", ramaddr, 32'h600);
    checkOutput("t6_reserve_iwait", iwait, 0);
    checkOutput("t6_reserve_iload", iload, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_end_iwait", iwait, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
